// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message-schedule slice: word width,
// controller state encoding, small-sigma rotate/shift amounts, the round
// constant table K and a rotate helper.
package sha256_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3 ; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  localparam logic [WORD-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int n);
    return (x >> n) | (x << (WORD - n));
  endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// Combinational SHA-256 small-sigma functions on one 32-bit word.
module sha256_small_sigma
  import sha256_pkg::*;
(
  input  logic [WORD-1:0] x,
  output logic [WORD-1:0] s0,
  output logic [WORD-1:0] s1
);

  assign s0 = rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
  assign s1 = rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator. Loads a 512-bit padded block and emits
// W0..W(ROUNDS-1) over a valid/ready handshake from a 16-word sliding window;
// the next window word is produced while the current one is presented, so
// words stream at one per cycle with no extra latency.
// Optional macro SHA256_MSG_SCHEDULE_KI_EN adds out_Ki = K[out_index],
// aligned with out_Wi.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] in_block,
  input  logic         in_load,
  input  logic         in_Wi_ready,
  output logic [31:0]  out_Wi,
  output logic         out_Wi_valid,
  output logic [5:0]   out_index,
  output logic         out_busy,
  output logic         out_done
`ifdef SHA256_MSG_SCHEDULE_KI_EN
  ,
  output logic [31:0]  out_Ki
`endif
);

  state_t          state_q, state_d;
  logic [5:0]      index_q;
  logic [WORD-1:0] w_q [16];

  logic            load_acc;
  logic            xfer;
  logic            last;
  logic [WORD-1:0] s0_w1, s1_w14;
  logic [WORD-1:0] unused_s1_w1, unused_s0_w14;
  logic [WORD-1:0] w_next;

  // Only sigma0 of w[1] and sigma1 of w[14] feed the recurrence.
  sha256_small_sigma u_sigma_w1 (
    .x  (w_q[1]),
    .s0 (s0_w1),
    .s1 (unused_s1_w1)
  );

  sha256_small_sigma u_sigma_w14 (
    .x  (w_q[14]),
    .s0 (unused_s0_w14),
    .s1 (s1_w14)
  );

  assign w_next   = s1_w14 + w_q[9] + s0_w1 + w_q[0];
  assign load_acc = (state_q == ST_IDLE) && in_load;
  assign xfer     = (state_q == ST_RUN) && in_Wi_ready;
  assign last     = (index_q == 6'(ROUNDS - 1));

  // Next-state logic: IDLE -> RUN on load, RUN -> DONE on last transfer,
  // DONE always returns to IDLE (loads during DONE are dropped).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_load)     state_d = ST_RUN;
      ST_RUN:  if (xfer && last) state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Word index: cleared on load, advanced on each non-final transfer.
  always_ff @(posedge clk) begin
    if (rst)                index_q <= '0;
    else if (load_acc)      index_q <= '0;
    else if (xfer && !last) index_q <= index_q + 6'd1;
  end

  // Sliding window: capture the block on load, shift in the next word on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 16; j++) w_q[j] <= '0;
    end else if (load_acc) begin
      for (int j = 0; j < 16; j++) w_q[j] <= in_block[511 - 32*j -: 32];
    end else if (xfer) begin
      for (int j = 0; j < 15; j++) w_q[j] <= w_q[j+1];
      w_q[15] <= w_next;
    end
  end

  // Outputs are zero outside RUN so leftover window contents never leak.
  always_comb begin
    out_Wi_valid = (state_q == ST_RUN);
    out_Wi       = out_Wi_valid ? w_q[0] : '0;
    out_index    = out_Wi_valid ? index_q : '0;
    out_busy     = (state_q != ST_IDLE);
    out_done     = (state_q == ST_DONE);
  end

`ifdef SHA256_MSG_SCHEDULE_KI_EN
  // Round constant for the word currently presented.
  always_comb begin
    out_Ki = out_Wi_valid ? K[index_q] : '0;
  end
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

  localparam int ROUNDS = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_block;
  logic         in_load;
  logic         in_Wi_ready;
  logic [31:0]  out_Wi;
  logic         out_Wi_valid;
  logic [5:0]   out_index;
  logic         out_busy;
  logic         out_done;
`ifdef SHA256_MSG_SCHEDULE_KI_EN
  logic [31:0]  out_Ki;
`endif

  sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_block     (in_block),
    .in_load      (in_load),
    .in_Wi_ready  (in_Wi_ready),
    .out_Wi       (out_Wi),
    .out_Wi_valid (out_Wi_valid),
    .out_index    (out_index),
    .out_busy     (out_busy),
    .out_done     (out_done)
`ifdef SHA256_MSG_SCHEDULE_KI_EN
    ,
    .out_Ki       (out_Ki)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] kt [64];
  logic [31:0] mw [64];
  int          m_state = 0;
  int          m_idx   = 0;
  int          cyc     = 0;
  int          last_load = 0;
  int          prev_load = 0;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build(input logic [511:0] b, output logic [31:0] w [64]);
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
  endtask

  always @(posedge clk) begin : model
    logic [31:0] tmpw [64];
    cyc <= cyc + 1;
    if (rst) begin
      m_state <= 0;
      m_idx   <= 0;
    end else begin
      case (m_state)
        0: if (in_load) begin
             build(in_block, tmpw);
             mw        <= tmpw;
             m_idx     <= 0;
             m_state   <= 1;
             prev_load <= last_load;
             last_load <= cyc;
           end
        1: if (in_Wi_ready) begin
             if (m_idx == ROUNDS - 1) m_state <= 2;
             else                     m_idx   <= m_idx + 1;
           end
        default: m_state <= 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  logic        chk_en   = 1'b0;

  always @(negedge clk) begin : compare
    logic        run;
    logic [31:0] a [6];
    logic [31:0] e [6];
    string       nm [6];
    if (chk_en) begin
      run  = (m_state == 1);
      nm[0] = "valid"; a[0] = 32'(out_Wi_valid); e[0] = 32'(run);
      nm[1] = "Wi";    a[1] = out_Wi;            e[1] = run ? mw[m_idx] : 32'h0;
      nm[2] = "index"; a[2] = 32'(out_index);    e[2] = run ? 32'(m_idx) : 32'h0;
      nm[3] = "busy";  a[3] = 32'(out_busy);     e[3] = 32'(m_state != 0);
      nm[4] = "done";  a[4] = 32'(out_done);     e[4] = 32'(m_state == 2);
`ifdef SHA256_MSG_SCHEDULE_KI_EN
      nm[5] = "Ki";    a[5] = out_Ki;            e[5] = run ? kt[m_idx] : 32'h0;
`else
      nm[5] = "";      a[5] = 32'h0;             e[5] = 32'h0;
`endif
      for (int i = 0; i < 6; i++) begin
        if (i == 5 && nm[5] == "") continue;
        n_assert++;
        if (a[i] !== e[i]) begin
          n_fail++;
          $display("FAIL %s cyc=%0d idx=%0d: got %h expected %h", nm[i], cyc, m_idx, a[i], e[i]);
        end
      end
      if (out_done) n_done++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL check %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [511:0] b);
    in_block = b;
    in_load  = 1'b1;
    @(posedge clk); #1;
    in_load  = 1'b0;
  endtask

  task automatic run_block(input bit rnd, input int act_idx, input int act_kind);
    bit acted = 0;
    bit ok    = 0;
    in_Wi_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      in_load = 1'b0;
      rst     = 1'b0;
      in_Wi_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_state == 0) begin ok = 1; break; end
      if (!acted && m_state == 1 && m_idx == act_idx) begin
        acted = 1;
        if (act_kind == 1) begin
          in_block = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
          in_load  = 1'b1;
        end else if (act_kind == 2) begin
          rst = 1'b1;
        end
      end
    end
    if (!ok) check("run_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int j = 0; j < 16; j++) b[511 - 32*j -: 32] = $urandom;
    return b;
  endfunction

  logic [511:0] abc_blk;
  logic [31:0]  pinw [64];
  int           d0;
  bit           ok;

  initial begin
    kt = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    abc_blk     = {32'h61626380, 448'h0, 32'h00000018};
    rst         = 1'b1;
    in_load     = 1'b0;
    in_Wi_ready = 1'b0;
    in_block    = '0;

    @(posedge clk); #1;
    n_assert++;
    if ({out_Wi, out_Wi_valid, out_index, out_busy, out_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: Wi=%h valid=%b index=%0d busy=%b done=%b",
               out_Wi, out_Wi_valid, out_index, out_busy, out_done);
    end
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    build(abc_blk, pinw);
    check("pin_W0",  pinw[0],  32'h61626380);
    check("pin_W15", pinw[15], 32'h00000018);
    check("pin_W16", pinw[16], 32'h61626380);
    check("pin_W17", pinw[17], 32'h000F0000);
    check("pin_W18", pinw[18], 32'h7DA86405);
    check("pin_K0",  kt[0],    32'h428A2F98);
    check("pin_K63", kt[63],   32'hC67178F2);

    d0 = n_done;
    load(abc_blk);
    run_block(0, -1, 0);
    check("done_cnt_abc", 32'(n_done - d0), 32'd1);

    d0 = n_done;
    load(abc_blk);
    run_block(1, -1, 0);
    check("done_cnt_stall", 32'(n_done - d0), 32'd1);

    d0 = n_done;
    load(abc_blk);
    run_block(0, 10, 1);
    check("done_cnt_ignload", 32'(n_done - d0), 32'd1);

    d0 = n_done;
    load(abc_blk);
    run_block(1, 30, 2);
    check("done_cnt_rst", 32'(n_done - d0), 32'd0);
    load(rand_block());
    run_block(1, -1, 0);

    in_Wi_ready = 1'b1;
    load('0);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_state == 2) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("b2b_done_timeout", 32'd1, 32'd0);
    in_block = abc_blk;
    in_load  = 1'b1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m_state == 1) begin ok = 1; break; end
    end
    in_load = 1'b0;
    if (!ok) check("b2b_load_timeout", 32'd1, 32'd0);
    check("b2b_gap", 32'(last_load - prev_load), 32'(ROUNDS + 2));
    run_block(1, -1, 0);

    for (int b = 0; b < 3; b++) begin
      load(rand_block());
      run_block(1, -1, 0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
